// File: rtl/mem_port_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types for the IF/LS memory port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      M_IF = 1'b0,
      M_LS = 1'b1
   } arb_master_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Request/ack bundle for the two masters plus the memory-side bus.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              MemReadWrite;
   logic              if_ack;
   logic              ls_ack;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   // Requesting side (control unit)
   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
      input  if_ack, ls_ack, rdata, busy
   );

   // Arbiter side
   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      output mem_addr, mem_wdata, MemReadWrite, if_ack, ls_ack, rdata, busy
   );

   // Memory side
   modport memory (
      input  mem_addr, mem_wdata, MemReadWrite,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_wait_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_wait_counter
//  Purpose  : Loadable down-counter with zero flag; times memory read latency.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wait_counter #(
   parameter int WIDTH = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_load_val,
   input  wire logic             i_dec,
   output logic                  o_zero
);
   logic [WIDTH-1:0] r_cnt;

   // Load takes precedence; decrement saturates at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between instruction fetch and load/store.
//             IDLE -> ACCESS -> DONE -> IDLE; one-cycle ack, registered rdata.
//  Config   : MEM_ARB_ROUND_ROBIN_EN defined   -> round-robin on contention
//             MEM_ARB_ROUND_ROBIN_EN undefined -> LS has fixed priority
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  wire logic         clock,
   input  wire logic         reset,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   arb_state_t        r_state;
   arb_master_t       r_master;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_we;
   logic              r_mrw;
   logic              r_if_ack;
   logic              r_ls_ack;
   logic              r_busy;

   logic              w_any_req;
   arb_master_t       w_grant;
   logic              w_cnt_load;
   logic              w_cnt_dec;
   logic              w_cnt_zero;

   assign w_any_req = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   arb_master_t r_last_grant;

   // Contention goes to the master that did not win last time.
   always_comb begin
      w_grant = bus.ls_req ? M_LS : M_IF;
      if (bus.if_req && bus.ls_req) begin
         w_grant = (r_last_grant == M_IF) ? M_LS : M_IF;
      end
   end

   // Remember the winner of every grant.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_last_grant <= M_IF;
      end else if ((r_state == IDLE) && w_any_req) begin
         r_last_grant <= w_grant;
      end
   end
`else
   // Fixed priority: load/store beats fetch.
   always_comb begin
      w_grant = bus.ls_req ? M_LS : M_IF;
   end
`endif

   assign w_cnt_load = (r_state == IDLE) && w_any_req;
   assign w_cnt_dec  = (r_state == ACCESS) && !r_we;

   mem_wait_counter #(
      .WIDTH(CNT_W)
   ) u_wait_cnt (
      .clk       (clock),
      .rst       (reset),
      .i_load    (w_cnt_load),
      .i_load_val(C_CNT_LOAD),
      .i_dec     (w_cnt_dec),
      .o_zero    (w_cnt_zero)
   );

   // Access sequencer: grant and latch in IDLE, time the access, pulse ack.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_master <= M_IF;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_we     <= 1'b0;
         r_mrw    <= 1'b0;
         r_if_ack <= 1'b0;
         r_ls_ack <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_master <= w_grant;
                  r_busy   <= 1'b1;
                  r_state  <= ACCESS;
                  if (w_grant == M_LS) begin
                     r_addr  <= bus.ls_addr;
                     r_wdata <= bus.ls_wdata;
                     r_we    <= bus.ls_we;
                     r_mrw   <= bus.ls_we;
                  end else begin
                     r_addr  <= bus.if_addr;
                     r_we    <= 1'b0;
                     r_mrw   <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               // Writes take one cycle; reads wait for the counter.
               if (r_we || w_cnt_zero) begin
                  if (!r_we) begin
                     r_rdata <= bus.mem_rdata;
                  end
                  r_mrw    <= 1'b0;
                  r_if_ack <= (r_master == M_IF);
                  r_ls_ack <= (r_master == M_LS);
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_if_ack <= 1'b0;
               r_ls_ack <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_addr     = r_addr;
   assign bus.mem_wdata    = r_wdata;
   assign bus.MemReadWrite = r_mrw;
   assign bus.if_ack       = r_if_ack;
   assign bus.ls_ack       = r_ls_ack;
   assign bus.rdata        = r_rdata;
   assign bus.busy         = r_busy;
endmodule
`default_nettype wire
